imem_loader: RTL and testbench

Instruction memory with a byte-serial program-load (write) port and a request/response read port for the fetch stage.
- A host streams program bytes over a valid/ready handshake.
- The block assembles the bytes into 32-bit words, fills memory sequentially, then raises load_done.
- Fetch reads return one cycle after request and flag out-of-range or not-yet-loaded addresses.

---
 rtl/imem_pkg.sv | 26 ++
 rtl/byte_assembler.sv | 48 ++++
 rtl/imem_loader.sv | 136 +++++++++++++
 tb/tb_imem_loader.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared constants, FSM state type and count check for the instruction-memory loader.
package imem_pkg;

    localparam int DEPTH          = 8;
    localparam int ADDR_W         = 4;
    localparam int DATA_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = ADDR_W + 1;
    localparam int IDX_W = $clog2(BYTES_PER_WORD);

    localparam logic [DATA_W-1:0] NOP_WORD = 32'h0;

    typedef enum logic [1:0] {
        IDLE,
        LOADING,
        READY
    } state_e;

    // A session must load between one word and the full memory.
    function automatic logic count_legal(input logic [CNT_W-1:0] cnt);
        return (cnt != '0) && (cnt <= CNT_W'(DEPTH));
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// Collects little-endian program bytes into a word; flags the word on its last byte.
module byte_assembler
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              byte_en_i,
    input  logic [7:0]        byte_i,
    output logic [DATA_W-1:0] word_o,
    output logic              word_valid_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
    logic [DATA_W-9:0] low_bytes_q, low_bytes_d;

    always_comb begin
        // NOTE: defaults first on every combinational output, so no path can infer a latch.
        byte_idx_d  = byte_idx_q;
        low_bytes_d = low_bytes_q;
        if (clear_i) begin
            byte_idx_d  = '0;
            low_bytes_d = '0;
        end else if (byte_en_i) begin
            if (byte_idx_q != LAST_IDX) begin
                low_bytes_d[8*byte_idx_q +: 8] = byte_i;
            end
            byte_idx_d = byte_idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx_q  <= '0;
            low_bytes_q <= '0;
        end else begin
            byte_idx_q  <= byte_idx_d;
            low_bytes_q <= low_bytes_d;
        end
    end

    // The top byte bypasses the register so the word is written on the edge that accepts it.
    assign word_o       = {byte_i, low_bytes_q};
    assign word_valid_o = byte_en_i && !clear_i && (byte_idx_q == LAST_IDX);

endmodule

// File: rtl/imem_loader.sv
// Instruction memory: byte-serial program load session, then one-cycle fetch reads.
module imem_loader
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              load_done,
    output logic              load_err,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_err
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   loaded_cnt_q, loaded_cnt_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic               load_err_q, load_err_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic               fetch_valid_q;
    logic [DATA_W-1:0]  fetch_data_q;
    logic               fetch_err_q;

    logic               asm_clear;
    logic               byte_accept;
    logic [DATA_W-1:0]  asm_word;
    logic               asm_word_valid;
    logic               mem_we;
    logic               fetch_hit;

    // A restarting load_start blocks byte acceptance for that cycle.
    assign byte_ready  = (state_q == LOADING) && !load_start;
    assign load_done   = (state_q == READY);
    assign load_err    = load_err_q;
    assign byte_accept = byte_valid && byte_ready;

    byte_assembler u_byte_assembler (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (asm_clear),
        .byte_en_i    (byte_accept),
        .byte_i       (byte_data),
        .word_o       (asm_word),
        .word_valid_o (asm_word_valid)
    );

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        loaded_cnt_d = loaded_cnt_q;
        load_err_d   = 1'b0;
        asm_clear    = 1'b0;
        mem_we       = 1'b0;

        if (load_start) begin
            asm_clear = 1'b1;
            if (count_legal(word_count)) begin
                state_d      = LOADING;
                count_d      = word_count;
                wr_ptr_d     = '0;
                loaded_cnt_d = '0;
            end else begin
                load_err_d = 1'b1;
                if (state_q == LOADING) begin
                    state_d = IDLE;
                end
            end
        end else if ((state_q == LOADING) && asm_word_valid) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (CNT_W'(wr_ptr_q) + CNT_W'(1) == count_q) begin
                state_d      = READY;
                loaded_cnt_d = count_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!rst_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            loaded_cnt_q <= '0;
            wr_ptr_q     <= '0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            loaded_cnt_q <= loaded_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            load_err_q   <= load_err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the array is cleared on reset because stale words must never be fetchable; this rules out a RAM macro.
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= NOP_WORD;
            end
        end else if (mem_we) begin
            mem_q[wr_ptr_q] <= asm_word;
        end
    end

    // Reads see pre-edge state, so a fetch alongside the final write still reports an error.
    assign fetch_hit = (state_q == READY) && (CNT_W'(fetch_addr) < loaded_cnt_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= NOP_WORD;
            fetch_err_q   <= 1'b0;
        end else begin
            fetch_valid_q <= fetch_req;
            if (fetch_req) begin
                fetch_data_q <= fetch_hit ? mem_q[fetch_addr[PTR_W-1:0]] : NOP_WORD;
                fetch_err_q  <= !fetch_hit;
            end
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_data  = fetch_data_q;
    assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a model predicts each fetch response when it is issued.
module tb_imem_loader;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_start;
    logic [4:0]  word_count;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        load_done;
    logic        load_err;
    logic        fetch_req;
    logic [3:0]  fetch_addr;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        fetch_err;

    resp_t       exp_q[$];
    logic [31:0] model_mem [8];
    int          model_cnt;
    bit          model_ready;
    int          checks = 0;
    int          errors = 0;
    logic        pend;
    logic [31:0] last_exp;

    always #5 clk = ~clk;

    imem_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .word_count  (word_count),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .load_done   (load_done),
        .load_err    (load_err),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .fetch_err   (fetch_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // A response is due on every cycle after a sampled request.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend <= 1'b0;
        else        pend <= fetch_req;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            last_exp = 32'h0;
        end else if (pend || fetch_valid) begin
            check("fetch_valid", 32'(fetch_valid), 32'(pend));
            if (pend) begin
                check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    resp_t r;
                    r = exp_q.pop_front();
                    check("fetch_data", fetch_data, r.data);
                    check("fetch_err", 32'(fetch_err), 32'(r.err));
                    last_exp = r.data;
                end
            end
        end else begin
            check("fetch_hold", fetch_data, last_exp);
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 8; i++) model_mem[i] = 32'h0;
        model_cnt   = 0;
        model_ready = 0;
    endtask

    task automatic push_fetch(input int a);
        resp_t r;
        r.err  = !(model_ready && (a < model_cnt));
        r.data = r.err ? 32'h0 : model_mem[a % 8];
        fetch_req  = 1'b1;
        fetch_addr = 4'(a);
        exp_q.push_back(r);
    endtask

    task automatic drain();
        int n = 0;
        #1;
        while (exp_q.size() != 0 && n < 4) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("sb_drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic fetch_list(input int addrs[$]);
        foreach (addrs[i]) begin
            @(negedge clk);
            push_fetch(addrs[i]);
        end
        @(negedge clk);
        fetch_req = 1'b0;
        drain();
    endtask

    task automatic start_load(input int cnt);
        bit legal;
        legal = (cnt >= 1) && (cnt <= 8);
        @(negedge clk);
        load_start = 1'b1;
        word_count = 5'(cnt);
        @(negedge clk);
        load_start = 1'b0;
        check("load_err_pulse", 32'(load_err), 32'(!legal));
        if (legal) begin
            model_ready = 0;
            model_cnt   = 0;
        end
        @(negedge clk);
        check("load_err_clear", 32'(load_err), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        #1;
        check("byte_ready", 32'(byte_ready), 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic load_words(input logic [31:0] words[$], input bit gaps, input bit fetch_last);
        int n;
        n = words.size();
        start_load(n);
        for (int w = 0; w < n; w++) begin
            for (int b = 0; b < 4; b++) begin
                logic [31:0] wd;
                bit          last;
                wd   = words[w];
                last = (w == n - 1) && (b == 3);
                repeat (gaps ? $urandom_range(0, 2) : 0) @(negedge clk);
                byte_valid = 1'b1;
                byte_data  = wd[8*b +: 8];
                if (last) begin
                    check("load_done_pre", 32'(load_done), 32'd0);
                    if (fetch_last) push_fetch(0);
                end
                #1;
                check("byte_ready", 32'(byte_ready), 32'd1);
                @(negedge clk);
                byte_valid = 1'b0;
                fetch_req  = 1'b0;
            end
        end
        for (int w = 0; w < n; w++) model_mem[w] = words[w];
        model_cnt   = n;
        model_ready = 1;
        check("load_done", 32'(load_done), 32'd1);
        check("byte_ready_done", 32'(byte_ready), 32'd0);
        if (fetch_last) drain();
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        check("rst_fetch_data", fetch_data, 32'h0);
        check("rst_fetch_err", 32'(fetch_err), 32'd0);
        check("rst_load_err", 32'(load_err), 32'd0);
        model_clear();
        exp_q.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] words[$];
        rst_n      = 1'b1;
        load_start = 1'b0;
        word_count = '0;
        byte_valid = 1'b0;
        byte_data  = '0;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        model_clear();

        // Reset values, then a fetch before anything is loaded.
        pulse_reset();
        fetch_list('{0});

        // Illegal counts from IDLE.
        start_load(0);
        start_load(9);
        check("idle_byte_ready", 32'(byte_ready), 32'd0);
        check("idle_load_done", 32'(load_done), 32'd0);

        // Two-word load with byte_valid held; a fetch alongside the final byte sees the old state.
        words = '{32'h04030201, 32'h08070605};
        load_words(words, 1'b0, 1'b1);
        fetch_list('{0, 1, 2, 15});

        // Full eight-word load with random gaps, read back at full throughput.
        words.delete();
        for (int i = 0; i < 8; i++) words.push_back($urandom);
        load_words(words, 1'b1, 1'b0);
        fetch_list('{0, 1, 2, 3, 4, 5, 6, 7, 8});

        // Restart mid-word: partial bytes and the byte offered with load_start are dropped.
        start_load(2);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        load_start = 1'b1;
        word_count = 5'd1;
        byte_valid = 1'b1;
        byte_data  = 8'hEE;
        #1;
        check("restart_byte_ready", 32'(byte_ready), 32'd0);
        @(negedge clk);
        load_start = 1'b0;
        byte_valid = 1'b0;
        check("restart_load_err", 32'(load_err), 32'd0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 1);
        send_byte(8'hCC, 0);
        send_byte(8'hDD, 0);
        check("restart_load_done", 32'(load_done), 32'd1);
        model_mem[0] = 32'hDDCCBBAA;
        model_cnt    = 1;
        model_ready  = 1;
        fetch_list('{0, 1});

        // Illegal count while READY keeps the loaded image serviceable.
        start_load(9);
        check("ready_hold_done", 32'(load_done), 32'd1);
        fetch_list('{0});

        // Illegal count mid-load returns to IDLE.
        start_load(2);
        send_byte(8'h55, 0);
        start_load(0);
        check("abort_byte_ready", 32'(byte_ready), 32'd0);
        check("abort_load_done", 32'(load_done), 32'd0);
        fetch_list('{0});

        // Reset in the middle of a load.
        start_load(2);
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 0);
        pulse_reset();
        fetch_list('{0});
        words = '{32'h0};
        load_words(words, 1'b0, 1'b0);
        fetch_list('{0, 1});

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
